// File: rtl/traffic_phase_timer.sv
// traffic_phase_timer: per-phase seconds countdown behind a clock prescaler.
// It gives the traffic controller its time_out and shows the remaining seconds.
module traffic_phase_timer #(
   parameter int TICK_DIV  = 50_000_000,
   parameter int LONG_SEC  = 25,
   parameter int SHORT_SEC = 4,
   parameter int CNT_W     = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode_count,
   output logic             time_out,
   output logic [CNT_W-1:0] sec_left,
   output logic             tick
);
   localparam int PRE_W = $clog2(TICK_DIV);
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] LONG_N  = CNT_W'(LONG_SEC);
   localparam logic [CNT_W-1:0] SHORT_N = CNT_W'(SHORT_SEC);
   logic [PRE_W-1:0] pre;
   logic [CNT_W-1:0] sec_q;
   logic             expired;
   logic             mode_q;
   logic             reload;
   logic             wrap;
   // A pending reload masks time_out, so a held expiry cannot advance the controller twice.
   always_comb begin
      reload   = mode_count != mode_q;
      wrap     = pre == PRE_MAX;
      tick     = wrap & ~expired & ~reload & ~rst;
      time_out = expired & ~reload & ~rst;
      sec_left = rst ? LONG_N : sec_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         pre     <= '0;
         sec_q   <= LONG_N;
         expired <= 1'b0;
         mode_q  <= 1'b0;
      end else if (reload) begin
         mode_q  <= mode_count;
         pre     <= '0;
         expired <= 1'b0;
         sec_q   <= mode_count ? SHORT_N : LONG_N;
      end else if (!expired) begin
         pre <= wrap ? '0 : pre + 1'b1;
         if (tick) begin
            sec_q <= sec_q - 1'b1;
            if (sec_q == CNT_W'(1)) expired <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_traffic_phase_timer.sv
// tb_traffic_phase_timer: directed per-cycle vectors feed a scoreboard queue.
// A negedge monitor pops the queue and compares the DUT outputs, plus the LEDs of a small bench controller.
module tb_traffic_phase_timer;
   localparam int TD = 4;
   typedef struct {
      logic       r;
      logic       m;
      logic       ctl;
      logic       to;
      logic       tk;
      logic [2:0] sec;
      logic [2:0] led;
   } ent_t;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mode_count = 1'b0;
   logic       time_out;
   logic       tick;
   logic [2:0] sec_left;
   logic [1:0] st = 2'd0;
   logic [2:0] led = 3'b100;
   logic       to_s = 1'b0;
   ent_t       plan[$];
   ent_t       sb[$];
   ent_t       de;
   ent_t       me;
   int         total = 0;
   int         passed = 0;
   int         ncyc = 0;

   traffic_phase_timer #(.TICK_DIV(TD), .LONG_SEC(3), .SHORT_SEC(2), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .mode_count(mode_count),
      .time_out(time_out), .sec_left(sec_left), .tick(tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
   endtask

   task automatic add(input logic r, input logic m, input logic ctl, input logic to,
                      input logic [2:0] sec, input logic tk, input logic [2:0] l);
      ent_t e;
      e.r = r; e.m = m; e.ctl = ctl; e.to = to; e.sec = sec; e.tk = tk; e.led = l;
      plan.push_back(e);
   endtask

   // Cycle c after the phase's start edge: tick before each TD-th edge, expiry from edge n*TD on.
   task automatic count(input logic m, input int n, input int cycles, input logic ctl, input logic [2:0] l);
      for (int c = 0; c < cycles; c++)
         add(1'b0, m, ctl, c >= TD * n, (c >= TD * n) ? 3'd0 : 3'(n - c / TD),
             (c < TD * n) && (c % TD == TD - 1), l);
   endtask

   always @(negedge clk) begin
      if (sb.size() != 0) begin
         me = sb.pop_front();
         ncyc++;
         chk("time_out", ncyc, time_out, me.to);
         chk("sec_left", ncyc, sec_left, me.sec);
         chk("tick", ncyc, tick, me.tk);
         if (me.ctl) chk("led", ncyc, led, me.led);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish, %0d/%0d checked", passed, total);
      $fatal(1);
   end

   initial begin
      repeat (3) add(1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 3'b000);
      count(1'b0, 3, 40, 1'b0, 3'b000);
      add(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'b000);
      count(1'b1, 2, 12, 1'b0, 3'b000);
      // tick/reload collision: the reload wins and the short count starts cleanly
      add(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'b000);
      count(1'b0, 3, 11, 1'b0, 3'b000);
      add(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 3'b000);
      count(1'b1, 2, 10, 1'b0, 3'b000);
      add(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'b000);
      count(1'b0, 3, 8, 1'b0, 3'b000);
      add(1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 3'b000);
      count(1'b0, 3, 16, 1'b0, 3'b000);
      repeat (2) add(1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 3'b000);
      add(1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 3'b000);
      count(1'b1, 2, 10, 1'b0, 3'b000);
      // 0->1->0 glitch: two back-to-back reloads, the count restarts from the last
      add(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'b000);
      count(1'b0, 3, 6, 1'b0, 3'b000);
      add(1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 3'b000);
      add(1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 3'b000);
      count(1'b0, 3, 16, 1'b0, 3'b000);
      // closed loop: each phase is one pending-reload cycle, n*TD counting cycles, one expired cycle
      add(1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 3'b000);
      count(1'b0, 3, 13, 1'b1, 3'b100);
      add(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'b010);
      count(1'b0, 2, 9, 1'b1, 3'b010);
      add(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'b001);
      count(1'b0, 3, 13, 1'b1, 3'b001);
      add(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'b001);
      count(1'b0, 2, 9, 1'b1, 3'b001);
      add(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 3'b100);
      count(1'b0, 3, 4, 1'b1, 3'b100);
      while (plan.size() != 0) begin
         de = plan.pop_front();
         @(posedge clk);
         #1;
         if (!de.ctl) st = 2'd0;
         else if (to_s) st = st + 2'd1;
         led = (st == 2'd0) ? 3'b100 : (st == 2'd1) ? 3'b010 : 3'b001;
         rst = de.r;
         mode_count = de.ctl ? st[0] : de.m;
         sb.push_back(de);
         #2;
         to_s = time_out;
      end
      repeat (3) @(negedge clk);
      chk("drain", ncyc, sb.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
